bcd_scan_display: RTL and testbench

Four-digit multiplexed seven-segment driver that consumes the 4-bit BCD outputs of a cascade of `dec_counter` stages and drives a common-anode display. It captures the digit vector on a load strobe into a shadow register and time-multiplexes one digit at a time at a programmable scan rate. It also blanks leading zeros and flags non-BCD input. It sits directly downstream of the counter chain and directly drives board pins.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/bcd_scan_display_if.sv | 15 +
 rtl/bcd_to_seg.sv | 13 +
 rtl/bcd_scan_display.sv | 83 ++++++++
 tb/tb_bcd_scan_display.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and seven-segment decode table for the scan display
// Purpose: active-low segment patterns {g,f,e,d,c,b,a} and anode constants
//          used by bcd_to_seg and bcd_scan_display.
// Ports:   none (package).
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Element k is the pattern for value k; 10..15 render as a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - digit load and display pin bundle for bcd_scan_display
// Purpose: groups the digit/load inputs and the seg/an/err outputs.
// Ports:   digits[15:0], load (toward display); seg[6:0], an[3:0], err (from display).
interface bcd_scan_display_if;

    logic [15:0] digits;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;

    modport master (output digits, load, input seg, an, err);
    modport slave  (input digits, load, output seg, an, err);

endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational 4-bit value to active-low seven-segment decode
// Purpose: looks up the segment pattern for one digit.
// Ports:   bcd[3:0] in, seg[6:0] out ({g,f,e,d,c,b,a}, active low).
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - four-digit multiplexed common-anode seven-segment driver
// Purpose: captures a BCD digit vector on load, scans one digit per SCAN_DIV
//          cycles starting with digit 0, blanks leading zeros, flags non-BCD.
// Ports:   clk, reset (async, active high), bus (slave: digits, load in;
//          seg, an, err out, all registered).
module bcd_scan_display
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic                clk,
    input  logic                reset,
    bcd_scan_display_if.slave   bus
);

    localparam int              PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [15:0]   shadow;
    logic          tick;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic          blank;
    logic          any_bad;

    assign tick     = (presc == PRE_LAST);
    assign idx_next = idx + 2'd1;

    // The slot being entered is decoded from the shadow as it stands before
    // this edge, so a load coinciding with a tick only shows from the next slot.
    assign cur_digit = shadow[{idx_next, 2'b00} +: 4];

    // Digit k is a leading zero when digits k..3 are all zero.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ && (idx_next != 2'd0))
            blank = ((shadow >> {idx_next, 2'b00}) == 16'h0000);
    end

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < 4; k++)
            if (shadow[k*4 +: 4] > 4'd9)
                any_bad = 1'b1;
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            idx     <= 2'd3;
            shadow  <= 16'h0000;
            bus.an  <= AN_OFF;
            bus.seg <= SEG_BLANK;
            bus.err <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            bus.err <= any_bad;
            if (bus.load)
                shadow <= bus.digits;
            if (tick) begin
                idx <= idx_next;
                if (blank) begin
                    bus.an  <= AN_OFF;
                    bus.seg <= SEG_BLANK;
                end else begin
                    bus.an  <= ~(4'b0001 << idx_next);
                    bus.seg <= dec_seg;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

    localparam int SD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bcd_scan_display_if bus ();

    bcd_scan_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cyc;
    logic [15:0] m_sh;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_err;

    typedef struct {
        logic [15:0]      d;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
        logic             err;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [6:0] ref_dec(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // One clock edge: advance the reference model using the inputs held
    // across the edge, then compare all outputs 1 time unit later.
    task automatic step();
        logic [15:0] old;
        int k;
        int v;
        @(posedge clk);
        old = m_sh;
        cyc++;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++)
            if (((old >> (4*i)) & 16'hF) > 9) m_err = 1'b1;
        if (cyc % SD == 0) begin
            k = (cyc / SD - 1) % 4;
            v = int'((old >> (4*k)) & 16'hF);
            if (k != 0 && (old >> (4*k)) == 0) begin
                m_an  = 4'b1111;
                m_seg = 7'b1111111;
            end else begin
                m_an  = ~(4'b0001 << k);
                m_seg = ref_dec(v);
            end
        end
        if (bus.load) m_sh = bus.digits;
        #1;
        chk("model_an",  16'(bus.an),  16'(m_an));
        chk("model_seg", 16'(bus.seg), 16'(m_seg));
        chk("model_err", 16'(bus.err), 16'(m_err));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.load = 1'b0;
        m_sh = 16'h0; m_an = 4'hF; m_seg = 7'h7F; m_err = 1'b0;
        #1;
        chk("rst_an",  16'(bus.an),  16'hF);
        chk("rst_seg", 16'(bus.seg), 16'h7F);
        chk("rst_err", 16'(bus.err), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        int k;
        logic [15:0] d;

        vecs[0] = '{d: 16'h1234, an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, err: 1'b0};
        vecs[1] = '{d: 16'h0050, an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    seg: {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, err: 1'b0};
        vecs[2] = '{d: 16'h0000, an: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, err: 1'b0};
        vecs[3] = '{d: 16'h0500, an: {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    seg: {7'b1111111, 7'b0010010, 7'b1000000, 7'b1000000}, err: 1'b0};
        vecs[4] = '{d: 16'h00A1, an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    seg: {7'b1111111, 7'b1111111, 7'b0111111, 7'b1111001}, err: 1'b1};

        bus.digits = 16'h0;
        bus.load   = 1'b0;
        cyc        = 0;

        // Reset and first lit digit.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) chk("rst_hold_an", 16'(bus.an), 16'hF);
        end
        chk("first_an",  16'(bus.an),  16'hE);
        chk("first_seg", 16'(bus.seg), 16'h40);

        // Table-driven scan patterns.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.digits = vecs[v].d;
            bus.load   = 1'b1;
            step();
            bus.load   = 1'b0;
            step();
            chk("vec_err", 16'(bus.err), 16'(vecs[v].err));
            while (cyc < 4 * SD) begin
                step();
                if (cyc % SD == 0) begin
                    k = cyc / SD - 1;
                    chk("vec_an",  16'(bus.an),  16'(vecs[v].an[k]));
                    chk("vec_seg", 16'(bus.seg), 16'(vecs[v].seg[k]));
                end
            end
        end

        // Clearing the invalid digit drops err one edge after the load edge.
        bus.digits = 16'h0001;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        chk("err_still_set", 16'(bus.err), 16'h1);
        step();
        chk("err_cleared", 16'(bus.err), 16'h0);

        // Load coinciding with the tick that enters slot 0.
        do_reset();
        bus.digits = 16'h0003;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        while (cyc < 5 * SD - 1) step();
        bus.digits = 16'h0009;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        chk("coll_an",  16'(bus.an),  16'hE);
        chk("coll_seg", 16'(bus.seg), 16'h30);
        while (cyc < 9 * SD) step();
        chk("coll_next_seg", 16'(bus.seg), 16'h10);

        // Asynchronous reset in the middle of slot 2.
        do_reset();
        bus.digits = 16'h1234;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        while (cyc < 3 * SD) step();
        chk("mid_an_before", 16'(bus.an), 16'hB);
        #2;
        do_reset();
        while (cyc < SD) step();
        chk("mid_after_an",  16'(bus.an),  16'hE);
        chk("mid_after_seg", 16'(bus.seg), 16'h40);

        // Randomized loads against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 4; j++)
                    d[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                bus.digits = d;
                bus.load   = 1'b1;
            end else begin
                bus.load   = 1'b0;
                bus.digits = 16'($urandom);
            end
            step();
        end
        bus.load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
